// File: rtl/uart_pkg.sv
// Shared UART control vocabulary: datapath control codes, control-point bundle
// and transmitter state/select encodings.
package uart_pkg;

  typedef enum logic [2:0] {CLR, INC, NO, RST, SHIFT, NONE, LOAD} ctrl_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  typedef enum logic [1:0] {SEL_IDLE, SEL_START, SEL_DATA, SEL_STOP} tx_sel_t;

  typedef struct packed {
    ctrl_t baud;
    ctrl_t bit_cnt;
    ctrl_t shift;
    ctrl_t hold;
  } controlPoints_t;

endpackage

// File: rtl/tx_fsm.sv
// Transmitter sequencer: walks IDLE/START/DATA/STOP and issues datapath control
// points plus the line select for the state being entered.
module tx_fsm
  import uart_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           bit_tick,
  input  logic           last_bit,
  input  logic           hold_full,
  output controlPoints_t ctrl,
  output tx_sel_t        tx_sel,
  output tx_state_t      state
);

  tx_state_t state_reg;
  tx_state_t state_next;

  always_comb begin
    state_next = state_reg;
    ctrl       = '{baud: INC, bit_cnt: NO, shift: NONE, hold: NO};
    case (state_reg)
      IDLE: begin
        ctrl.baud    = CLR;
        ctrl.bit_cnt = CLR;
        if (hold_full) begin
          state_next = START;
          ctrl.shift = LOAD;
          ctrl.hold  = CLR;
        end
      end
      START: begin
        if (bit_tick) begin
          state_next   = DATA;
          ctrl.bit_cnt = CLR;
        end
      end
      DATA: begin
        if (bit_tick) begin
          ctrl.shift = SHIFT;
          if (last_bit) begin
            state_next   = STOP;
            ctrl.bit_cnt = CLR;
          end else begin
            ctrl.bit_cnt = INC;
          end
        end
      end
      STOP: begin
        // A word already waiting chains straight into the next start bit.
        if (bit_tick) begin
          ctrl.bit_cnt = CLR;
          if (hold_full) begin
            state_next = START;
            ctrl.shift = LOAD;
            ctrl.hold  = CLR;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Select follows the next state so the registered line changes on the transition edge.
  always_comb begin
    tx_sel = SEL_IDLE;
    case (state_next)
      IDLE:    tx_sel = SEL_IDLE;
      START:   tx_sel = SEL_START;
      DATA:    tx_sel = SEL_DATA;
      STOP:    tx_sel = SEL_STOP;
      default: tx_sel = SEL_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register with valid/ready intake, baud and
// bit counters, LSB-first shift register and a registered serial line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic [BAUD_W-1:0]    baud_cnt_reg, baud_cnt_next;
  logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] hold_reg, hold_next;
  logic                 hold_full_reg, hold_full_next;
  logic                 tx_reg, tx_next;
  logic [DATA_BITS-1:0] shift_right;

  logic           bit_tick;
  logic           last_bit;
  logic           handshake;
  controlPoints_t ctrl;
  tx_sel_t        tx_sel;
  tx_state_t      state;

  assign bit_tick  = (baud_cnt_reg == BAUD_LAST);
  assign last_bit  = (bit_cnt_reg == BIT_LAST);
  assign tx_ready  = !hold_full_reg;
  assign handshake = tx_valid && tx_ready;

  tx_fsm u_fsm (
    .clock     (clock),
    .reset     (reset),
    .bit_tick  (bit_tick),
    .last_bit  (last_bit),
    .hold_full (hold_full_reg),
    .ctrl      (ctrl),
    .tx_sel    (tx_sel),
    .state     (state)
  );

  genvar gi;
  generate
    for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
      if (gi == DATA_BITS - 1) begin : g_msb
        assign shift_right[gi] = 1'b0;
      end else begin : g_lower
        assign shift_right[gi] = shift_reg[gi+1];
      end
    end
  endgenerate

  always_comb begin
    baud_cnt_next = baud_cnt_reg;
    case (ctrl.baud)
      CLR:     baud_cnt_next = '0;
      INC:     baud_cnt_next = bit_tick ? '0 : baud_cnt_reg + BAUD_W'(1);
      default: baud_cnt_next = baud_cnt_reg;
    endcase

    bit_cnt_next = bit_cnt_reg;
    case (ctrl.bit_cnt)
      CLR:     bit_cnt_next = '0;
      INC:     bit_cnt_next = bit_cnt_reg + BIT_W'(1);
      default: bit_cnt_next = bit_cnt_reg;
    endcase

    shift_next = shift_reg;
    case (ctrl.shift)
      LOAD:    shift_next = hold_reg;
      SHIFT:   shift_next = shift_right;
      default: shift_next = shift_reg;
    endcase

    // Intake only happens when empty and consume only when full, so they never collide.
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    if (ctrl.hold == CLR) begin
      hold_full_next = 1'b0;
    end
    if (handshake) begin
      hold_next      = tx_data;
      hold_full_next = 1'b1;
    end

    tx_next = 1'b1;
    case (tx_sel)
      SEL_START: tx_next = 1'b0;
      SEL_DATA:  tx_next = shift_next[0];
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      baud_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      tx_reg        <= 1'b1;
    end else begin
      baud_cnt_reg  <= baud_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      tx_reg        <= tx_next;
    end
  end

  assign tx   = tx_reg;
  assign busy = (state != IDLE) || hold_full_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default instance (16 clks/bit, 8 bits) and a
// small instance (4 clks/bit, 7 bits), with hand-built expected line patterns.
module tb_uart_tx;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx, busy;

  logic [6:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2, tx2, busy2;

  int checks = 0;
  int errors = 0;

  uart_tx dut (
    .clock    (clock),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy)
  );

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(7)) dut2 (
    .clock    (clock),
    .reset    (reset),
    .tx_data  (tx_data2),
    .tx_valid (tx_valid2),
    .tx_ready (tx_ready2),
    .tx       (tx2),
    .busy     (busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0]  frame10;
    logic [19:0] frame20;
    logic [8:0]  frame9;

    // Reset with tx_valid high: no word may be captured.
    reset     = 1'b1;
    tx_valid  = 1'b1;
    tx_data   = 8'h99;
    tx_valid2 = 1'b0;
    tx_data2  = 7'h00;
    repeat (3) tick();
    check("rst_tx", tx, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    reset    = 1'b0;
    tx_valid = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_tx_ready_busy", {29'd0, tx, tx_ready, busy}, 32'b110);
    end
    $display("txn idle: 20 cycles after reset");

    // Single frame 0xA5.
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    check("a5_ready_low", tx_ready, 1'b0);
    check("a5_tx_before_start", tx, 1'b1);
    check("a5_busy_held", busy, 1'b1);
    frame10 = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 160; i++) begin
      tick();
      check("a5_tx", tx, frame10[i/16]);
      check("a5_busy", busy, 1'b1);
    end
    tick();
    check("a5_busy_end", busy, 1'b0);
    check("a5_tx_end", tx, 1'b1);
    check("a5_ready_end", tx_ready, 1'b1);
    $display("txn frame 0xA5 on default instance");

    // Back-to-back 0x3C then 0xC3 with tx_valid held; late data change to 0xFF ignored.
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    tick();
    tx_data = 8'hC3;
    frame20 = {1'b1, 8'hC3, 1'b0, 1'b1, 8'h3C, 1'b0};
    for (int i = 0; i < 320; i++) begin
      tick();
      check("b2b_tx", tx, frame20[i/16]);
      if (i == 0) begin
        check("b2b_ready_first_start", tx_ready, 1'b1);
      end else if (i == 1) begin
        check("b2b_ready_after_hs2", tx_ready, 1'b0);
        tx_data = 8'hFF;
      end else if (i < 160) begin
        check("b2b_ready_held", tx_ready, 1'b0);
      end else if (i == 160) begin
        check("b2b_ready_second_start", tx_ready, 1'b1);
        tx_valid = 1'b0;
      end
    end
    tick();
    check("b2b_busy_end", busy, 1'b0);
    check("b2b_tx_end", tx, 1'b1);
    $display("txn frames 0x3C,0xC3 back-to-back on default instance");

    // Reset midway through the data bits of 0xFF with 0x5A held.
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    tick();
    tx_data = 8'h5A;
    tick();
    tick();
    tx_valid = 1'b0;
    check("abort_held_ready", tx_ready, 1'b0);
    check("abort_held_busy", busy, 1'b1);
    repeat (40) tick();
    check("abort_busy_mid_data", busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_tx", tx, 1'b1);
    check("abort_ready", tx_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    for (int i = 0; i < 200; i++) begin
      tick();
      check("abort_quiet_tx_busy", {30'd0, tx, busy}, 32'b10);
    end
    $display("txn reset abort of 0xFF with 0x5A held");

    // Small instance: 7 data bits, 4 clocks per bit.
    tx_data2  = 7'h55;
    tx_valid2 = 1'b1;
    tick();
    tx_valid2 = 1'b0;
    check("p4_ready_low", tx_ready2, 1'b0);
    frame9 = {1'b1, 7'h55, 1'b0};
    for (int i = 0; i < 36; i++) begin
      tick();
      check("p4_tx", tx2, frame9[i/4]);
      check("p4_busy", busy2, 1'b1);
    end
    tick();
    check("p4_busy_end", busy2, 1'b0);
    check("p4_tx_end", tx2, 1'b1);
    $display("txn frame 0x55 on 4-clk/7-bit instance");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (minimum 2).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (range 5..9).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port tx_data, input, DATA_BITS bits: the word to transmit, sampled only on handshake.
REQ-006 The block SHALL have port tx_valid, input, 1 bit: the producer offers tx_data.
REQ-007 The block SHALL have port tx_ready, output, 1 bit: the holding register is empty and can accept a word.
REQ-008 The block SHALL have port tx, output, 1 bit: the serial line, idle high, registered.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a frame is on the line or a word is held.

Function
REQ-010 A handshake SHALL occur on an edge where tx_valid && tx_ready; tx_data is then copied into a one-entry holding register and hold_full is set.
REQ-011 tx_ready SHALL equal !hold_full; after a handshake it SHALL be low for at least one cycle, and tx_data changes after the handshake SHALL have no effect.
REQ-012 The FSM states SHALL be IDLE, START, DATA and STOP.
REQ-013 In IDLE with hold_full, the FSM SHALL go to START on the next edge, load the shift register from the holding register, clear hold_full, and clear the baud and bit counters.
REQ-014 Latency: for a handshake at edge k in IDLE, tx SHALL be 0 from edge k+1.
REQ-015 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; bit_tick SHALL be asserted at count CLKS_PER_BIT-1.
REQ-016 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-017 DATA SHALL drive bits LSB-first, each for CLKS_PER_BIT cycles, shifting right on bit_tick. The bit counter ($clog2(DATA_BITS) bits) SHALL increment on bit_tick, and the FSM SHALL go to STOP on the bit_tick where the count equals DATA_BITS-1.
REQ-018 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles. On its final bit_tick the FSM SHALL go to START if hold_full (no idle gap, shift register reloaded, hold_full cleared) and to IDLE otherwise.
REQ-019 A new word SHALL be accepted during START, DATA or STOP while the holding register is empty, which gives back-to-back frames.
REQ-020 busy SHALL equal (state != IDLE) || hold_full.
REQ-021 A frame SHALL be exactly (DATA_BITS+2)*CLKS_PER_BIT cycles long.

Reset
REQ-022 While reset is high at an edge: state SHALL become IDLE, tx=1, tx_ready=1, busy=0, hold_full=0, and the shift register and counters SHALL be 0.
REQ-023 Reset mid-frame SHALL abort the frame: tx SHALL be 1 from the following edge and any held word SHALL be discarded.
REQ-024 tx_valid asserted during reset SHALL NOT cause a handshake.

Structure
REQ-025 Package uart_pkg SHALL hold the shared counter/register control enum (CLR, INC, NO, RST, SHIFT, NONE, LOAD), the controlPoints_t struct, and the tx state enum, so that transmitter and receiver share one control vocabulary.
REQ-026 The FSM SHALL be the sub-module tx_fsm (inputs: bit_tick, last_bit, hold_full; outputs: controlPoints_t and the tx select). The counters, shift register and holding register SHALL live in uart_tx.

Verification
REQ-027 Reset, then idle 20 cycles -> tx=1, tx_ready=1, busy=0 throughout.
REQ-028 Defaults, send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each value held 16 cycles; busy falls 160 cycles after tx first goes low.
REQ-029 Offer 0x3C immediately followed by 0xC3 with tx_valid held high -> second handshake occurs during the first frame; 320 contiguous cycles with no idle-high gap between the stop bit and the second start bit.
REQ-030 Hold tx_valid high with the holding register full -> tx_ready=0 and no second handshake until the FSM enters START; an input word changed after a handshake is never transmitted.
REQ-031 Assert reset for 1 cycle midway through the DATA bits of 0xFF with a word held -> tx=1 on the next edge, tx_ready=1, busy=0, nothing further transmitted.
REQ-032 CLKS_PER_BIT=4, DATA_BITS=7, send 0x55 -> 36-cycle frame with data bits 1,0,1,0,1,0,1 each held 4 cycles.
